ex_issue_ctrl: RTL

Issue controller for the execute stage. It sits between decode and `ex`, holds a per-register scoreboard of pending writebacks, and stalls decode on RAW/WAW hazards and on writeback-port conflicts. It also serialises control-flow instructions until they resolve and pulses a front-end flush when a branch is taken.

---
 rtl/ex_issue_ctrl_if.sv | 46 ++++
 rtl/ex_issue_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ex_issue_ctrl_if.sv
// Decode/execute/writeback/branch signal bundle for the execute-stage issue controller.
// The master side is decode plus ex; the slave side is the issue controller.
interface ex_issue_ctrl_if #(
   parameter int XCNT    = 32,
   parameter int MAX_LAT = 4
);
   localparam int RW = $clog2(XCNT);
   localparam int LW = $clog2(MAX_LAT + 1);

   logic          DEC_VALID;
   logic          DEC_READY;
   logic [RW-1:0] DEC_RS1;
   logic [RW-1:0] DEC_RS2;
   logic          DEC_RS1_USED;
   logic          DEC_RS2_USED;
   logic [RW-1:0] DEC_RD;
   logic          DEC_RD_WRITE;
   logic [LW-1:0] DEC_LAT;
   logic          DEC_BRANCH;
   logic          EXECUTE_ENABLED;
   logic [RW-1:0] EX_RD_SEL;
   logic          EX_RD_WRITE;
   logic          EXECUTE_HAZARD;
   logic          WB_VALID;
   logic [RW-1:0] WB_SEL;
   logic          BRANCH_RESOLVED;
   logic          BRANCH_TAKEN;
   logic          FLUSH;
   logic [XCNT-1:0] BUSY_MASK;

   modport master (
      output DEC_VALID, DEC_RS1, DEC_RS2, DEC_RS1_USED, DEC_RS2_USED,
             DEC_RD, DEC_RD_WRITE, DEC_LAT, DEC_BRANCH,
             WB_VALID, WB_SEL, BRANCH_RESOLVED, BRANCH_TAKEN,
      input  DEC_READY, EXECUTE_ENABLED, EX_RD_SEL, EX_RD_WRITE,
             EXECUTE_HAZARD, FLUSH, BUSY_MASK
   );

   modport slave (
      input  DEC_VALID, DEC_RS1, DEC_RS2, DEC_RS1_USED, DEC_RS2_USED,
             DEC_RD, DEC_RD_WRITE, DEC_LAT, DEC_BRANCH,
             WB_VALID, WB_SEL, BRANCH_RESOLVED, BRANCH_TAKEN,
      output DEC_READY, EXECUTE_ENABLED, EX_RD_SEL, EX_RD_WRITE,
             EXECUTE_HAZARD, FLUSH, BUSY_MASK
   );
endinterface

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: register scoreboard, single writeback-port slot
// reservation, and control-flow serialisation with a one-cycle front-end flush.
module ex_issue_ctrl #(
   parameter int XCNT    = 32,
   parameter int MAX_LAT = 4
) (
   input logic           CLK,
   input logic           RST,
   ex_issue_ctrl_if.slave bus
);
   localparam int RW = $clog2(XCNT);
   localparam int LW = $clog2(MAX_LAT + 1);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_BR_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_t;

   state_t             state_r;
   logic [XCNT-1:0]    busy_r;
   logic [MAX_LAT-1:0] slot_r;
   logic               exec_en_r;
   logic [RW-1:0]      ex_rd_sel_r;
   logic               ex_rd_write_r;
   logic               flush_r;

   logic [LW-1:0]      lat_eff_s;
   logic [MAX_LAT-1:0] lat_mask_s;
   logic [XCNT-1:0]    set_mask_s;
   logic [XCNT-1:0]    clr_mask_s;
   logic               raw_s;
   logic               waw_s;
   logic               slot_s;
   logic               ready_s;
   logic               hs_s;

   // Effective latency (0 reads as 1, oversize clamps) and the slot bit it would claim.
   always_comb begin
      lat_eff_s = bus.DEC_LAT;
      if (bus.DEC_LAT == LW'(0)) begin
         lat_eff_s = LW'(1);
      end else if (bus.DEC_LAT > LW'(MAX_LAT)) begin
         lat_eff_s = LW'(MAX_LAT);
      end else begin
         lat_eff_s = bus.DEC_LAT;
      end
      lat_mask_s = MAX_LAT'(1) << (lat_eff_s - LW'(1));
   end

   // Hazard detection against the registered scoreboard only, plus handshake and mask updates.
   always_comb begin
      raw_s   = (bus.DEC_RS1_USED && (bus.DEC_RS1 != RW'(0)) && busy_r[bus.DEC_RS1]) ||
                (bus.DEC_RS2_USED && (bus.DEC_RS2 != RW'(0)) && busy_r[bus.DEC_RS2]);
      waw_s   = bus.DEC_RD_WRITE && (bus.DEC_RD != RW'(0)) && busy_r[bus.DEC_RD];
      slot_s  = |(slot_r & lat_mask_s);
      ready_s = (state_r == ST_RUN) && !RST && !raw_s && !waw_s && !slot_s;
      hs_s    = bus.DEC_VALID && ready_s;
      set_mask_s = {XCNT{1'b0}};
      clr_mask_s = {XCNT{1'b0}};
      if (hs_s && bus.DEC_RD_WRITE && (bus.DEC_RD != RW'(0))) begin
         set_mask_s = XCNT'(1) << bus.DEC_RD;
      end else begin
         set_mask_s = {XCNT{1'b0}};
      end
      if (bus.WB_VALID && (bus.WB_SEL != RW'(0))) begin
         clr_mask_s = XCNT'(1) << bus.WB_SEL;
      end else begin
         clr_mask_s = {XCNT{1'b0}};
      end
   end

   assign bus.DEC_READY       = ready_s;
   assign bus.EXECUTE_HAZARD  = (state_r == ST_RUN) && bus.DEC_VALID && (raw_s || waw_s || slot_s);
   assign bus.EXECUTE_ENABLED = exec_en_r;
   assign bus.EX_RD_SEL       = ex_rd_sel_r;
   assign bus.EX_RD_WRITE     = ex_rd_write_r;
   assign bus.FLUSH           = flush_r;
   assign bus.BUSY_MASK       = busy_r;

   // Control FSM, scoreboard, slot vector and registered issue/flush outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r       <= ST_RUN;
         busy_r        <= {XCNT{1'b0}};
         slot_r        <= {MAX_LAT{1'b0}};
         exec_en_r     <= 1'b0;
         ex_rd_sel_r   <= RW'(0);
         ex_rd_write_r <= 1'b0;
         flush_r       <= 1'b0;
      end else begin
         exec_en_r <= hs_s;
         if (hs_s) begin
            ex_rd_sel_r   <= bus.DEC_RD;
            ex_rd_write_r <= bus.DEC_RD_WRITE;
         end
         // Set after clear so a same-cycle set on the same register wins.
         busy_r  <= ((busy_r & ~clr_mask_s) | set_mask_s) & ~(XCNT'(1));
         slot_r  <= (slot_r | (hs_s ? lat_mask_s : {MAX_LAT{1'b0}})) >> 1'b1;
         flush_r <= 1'b0;
         case (state_r)
            ST_RUN: begin
               if (hs_s && bus.DEC_BRANCH) begin
                  state_r <= ST_BR_WAIT;
               end
            end
            ST_BR_WAIT: begin
               if (bus.BRANCH_RESOLVED) begin
                  flush_r <= bus.BRANCH_TAKEN;
                  state_r <= bus.BRANCH_TAKEN ? ST_FLUSH : ST_RUN;
               end
            end
            ST_FLUSH: begin
               state_r <= ST_RUN;
            end
            default: begin
               state_r <= ST_RUN;
            end
         endcase
      end
   end
endmodule
